// File: rtl/muldiv_sequencer.sv
// Multi-cycle multiply/divide sequencer for the EX stage; owns HI/LO and
// stalls HI/LO accesses or new mul/div ops while an operation is in flight.
module muldiv_sequencer #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic             stall,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t               state, state_nxt;
  logic [CW-1:0]        count;
  logic [2*WIDTH-1:0]   acc;
  logic [WIDTH-1:0]     opb, hi, lo;
  logic                 is_div, neg_q, neg_r, div0;

  logic                 is_muldiv, is_mt, is_hilo, accept;
  logic                 is_div_op, signed_op, a_neg, b_neg, div0_op;
  logic [WIDTH-1:0]     a_mag, b_mag;
  logic [WIDTH:0]       mul_sum, trial;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt, prod_fix;
  logic [WIDTH-1:0]     quo_fix, rem_fix;

  always_comb begin
    is_muldiv = (funct == F_MULT) || (funct == F_MULTU) ||
                (funct == F_DIV)  || (funct == F_DIVU);
    is_mt     = (funct == F_MTHI) || (funct == F_MTLO);
    is_hilo   = is_muldiv || is_mt || (funct == F_MFHI) || (funct == F_MFLO);
    accept    = valid && (state == IDLE) && is_muldiv;
    is_div_op = (funct == F_DIV) || (funct == F_DIVU);
    signed_op = (funct == F_MULT) || (funct == F_DIV);
    a_neg     = signed_op && dataA[WIDTH-1];
    b_neg     = signed_op && dataB[WIDTH-1];
    a_mag     = a_neg ? -dataA : dataA;
    b_mag     = b_neg ? -dataB : dataB;
    div0_op   = is_div_op && (dataB == '0);
  end

  // acc holds {partial product, multiplier} for mul and {remainder, quotient} for div
  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opb : {WIDTH{1'b0}})};
    mul_nxt  = {mul_sum, acc[WIDTH-1:1]};
    trial    = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    div_nxt  = trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                            : {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    prod_fix = neg_q ? -acc : acc;
    quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = div0_op ? FIX : RUN;
      RUN:     if (count == '0) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    done  = (state == FIX);
    stall = valid && busy && is_hilo;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hi     <= '0;
      lo     <= '0;
      acc    <= '0;
      opb    <= '0;
      count  <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      div0   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (valid && funct == F_MTHI) hi <= dataA;
          if (valid && funct == F_MTLO) lo <= dataA;
          if (accept) begin
            // divide-by-zero keeps the raw dividend so FIX can return it in HI
            acc    <= {{WIDTH{1'b0}}, (div0_op ? dataA : a_mag)};
            opb    <= b_mag;
            count  <= CW'(WIDTH - 1);
            is_div <= is_div_op;
            neg_q  <= a_neg ^ b_neg;
            neg_r  <= a_neg;
            div0   <= div0_op;
          end
        end
        RUN: begin
          acc   <= is_div ? div_nxt : mul_nxt;
          count <= count - 1'b1;
        end
        FIX: begin
          if (div0) begin
            hi <= acc[WIDTH-1:0];
            lo <= '1;
          end else if (is_div) begin
            hi <= rem_fix;
            lo <= quo_fix;
          end else begin
            hi <= prod_fix[2*WIDTH-1:WIDTH];
            lo <= prod_fix[WIDTH-1:0];
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_out = hi;
  assign lo_out = lo;

endmodule
